// File: rtl/sum_accum_n8.sv
// Folds CC consecutive N-bit words into one modulo-2^N sum with a sticky carry flag,
// then hands the result to the consumer over a valid/ready handshake.
module sum_accum_n8 #(
    parameter int N  = 8,
    parameter int CC = 4,
    localparam int CW = (CC > 1) ? $clog2(CC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  o,
    output logic          ovf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  acc;
    logic          ovf_r;
    logic [CW-1:0] cnt_r;
    logic [N:0]    sum;
    logic          accept;
    logic          last;

    assign sum  = {1'b0, acc} + {1'b0, in_data};
    assign last = (cnt_r == CW'(CC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Handshake outputs come only from the state register, never from inputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ovf_r <= 1'b0;
            cnt_r <= '0;
        end else if (accept) begin
            // First word of a group replaces whatever the previous group left behind.
            if (cnt_r == '0) begin
                acc   <= in_data;
                ovf_r <= 1'b0;
            end else begin
                acc   <= sum[N-1:0];
                ovf_r <= ovf_r | sum[N];
            end
            cnt_r <= last ? '0 : cnt_r + 1'b1;
        end
    end

    assign o   = acc;
    assign ovf = ovf_r;
    assign cnt = cnt_r;

endmodule
